// File: rtl/conv_sched_if.sv
// conv_sched_if: handshake and memory/MAC control bundle of the convolution
// sequencer. The scheduler side uses the master modport, the surrounding
// datapath (memories, MAC lanes, downstream sink) uses the slave modport.
interface conv_sched_if #(
  parameter int SIZE_X = 96,
  parameter int SIZE_F = 65,
  parameter int P      = 1
);
  localparam int POINTS = SIZE_X - SIZE_F + 1;
  localparam int PASSES = (POINTS + P - 1) / P;
  localparam int LX     = $clog2(SIZE_X);
  localparam int LF     = $clog2(SIZE_F);
  localparam int LY     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LP     = (P > 1) ? $clog2(P) : 1;

  logic          x_valid;
  logic          x_ready;
  logic          x_wr_en;
  logic [LX-1:0] x_addr;
  logic [LF-1:0] f_addr;
  logic          acc_clear;
  logic          acc_en;
  logic          y_wr_en;
  logic [LY-1:0] y_wr_addr;
  logic [LY-1:0] y_rd_addr;
  logic [LP-1:0] y_lane_sel;
  logic          y_valid;
  logic          y_ready;

  modport master (
    input  x_valid, y_ready,
    output x_ready, x_wr_en, x_addr, f_addr, acc_clear, acc_en,
           y_wr_en, y_wr_addr, y_rd_addr, y_lane_sel, y_valid
  );

  modport slave (
    output x_valid, y_ready,
    input  x_ready, x_wr_en, x_addr, f_addr, acc_clear, acc_en,
           y_wr_en, y_wr_addr, y_rd_addr, y_lane_sel, y_valid
  );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: sequencing controller for the 1-D convolution engine.
// Loads SIZE_X samples into x-memory, runs one pass of SIZE_F taps per group
// of P output points, waits for the MAC pipeline, stores lane results into the
// y buffers and finally streams the output points one word per two cycles.
// Optional feature macro: CONV_SCHED_DONE_EN adds `done` and `busy` outputs.
module conv_sched #(
  parameter int SIZE_X  = 96,
  parameter int SIZE_F  = 65,
  parameter int P       = 1,
  parameter int MAC_LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  conv_sched_if.master bus
`ifdef CONV_SCHED_DONE_EN
  ,
  output logic         done,
  output logic         busy
`endif
);
  localparam int POINTS = SIZE_X - SIZE_F + 1;
  localparam int PASSES = (POINTS + P - 1) / P;
  localparam int LX     = $clog2(SIZE_X);
  localparam int LF     = $clog2(SIZE_F);
  localparam int LY     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LP     = (P > 1) ? $clog2(P) : 1;
  localparam int LM     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int LK     = (POINTS > 1) ? $clog2(POINTS) : 1;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_FLUSH,
    ST_STORE,
    ST_DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [LX-1:0] load_cnt;
  logic [LX-1:0] x_base;
  logic [LF-1:0] tap;
  logic [LM-1:0] flush_cnt;
  logic [LY-1:0] pass_idx;
  logic [LY-1:0] rd_addr;
  logic [LP-1:0] lane_sel;
  logic [LK-1:0] point_idx;
  logic          y_valid_q;
  logic          acc_en_q;

  logic x_acc;
  logic y_hs;
  logic load_last;
  logic tap_last;
  logic flush_last;
  logic pass_last;
  logic point_last;
  logic lane_last;

  assign x_acc      = bus.x_valid & (state == ST_LOAD);
  assign y_hs       = (state == ST_DRAIN) & y_valid_q & bus.y_ready;
  assign load_last  = (load_cnt == LX'(SIZE_X - 1));
  assign tap_last   = (tap == LF'(SIZE_F - 1));
  assign flush_last = (flush_cnt == LM'(MAC_LAT - 1));
  assign pass_last  = (pass_idx == LY'(PASSES - 1));
  assign point_last = (point_idx == LK'(POINTS - 1));
  assign lane_last  = (lane_sel == LP'(P - 1));

  assign bus.x_wr_en    = x_acc;
  assign bus.f_addr     = tap;
  assign bus.acc_en     = acc_en_q;
  assign bus.y_wr_addr  = pass_idx;
  assign bus.y_rd_addr  = rd_addr;
  assign bus.y_lane_sel = lane_sel;
  assign bus.y_valid    = y_valid_q;

  // State register; reset abandons any frame in progress and returns to LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // Next-state decode plus the state-dependent strobes and x address mux.
  always_comb begin
    state_nxt     = state;
    bus.x_ready   = 1'b0;
    bus.acc_clear = 1'b0;
    bus.y_wr_en   = 1'b0;
    bus.x_addr    = load_cnt;
    case (state)
      ST_LOAD: begin
        bus.x_ready   = 1'b1;
        bus.acc_clear = 1'b1;
        if (x_acc && load_last) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        bus.x_addr = x_base + LX'(tap);
        if (tap_last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_last) state_nxt = ST_STORE;
      end
      ST_STORE: begin
        bus.y_wr_en   = 1'b1;
        bus.acc_clear = 1'b1;
        state_nxt     = pass_last ? ST_DRAIN : ST_COMPUTE;
      end
      ST_DRAIN: begin
        bus.acc_clear = 1'b1;
        if (y_hs && point_last) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Sample write address: advances only on accepted samples, wraps to 0 after the last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt <= '0;
    end else if (x_acc) begin
      load_cnt <= load_last ? '0 : load_cnt + LX'(1);
    end
  end

  // Pass sequencing: tap counter, MAC latency wait, pass index and lane-0 base address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap       <= '0;
      flush_cnt <= '0;
      pass_idx  <= '0;
      x_base    <= '0;
      acc_en_q  <= 1'b0;
    end else begin
      acc_en_q <= (state == ST_COMPUTE);
      if (state == ST_COMPUTE) begin
        tap <= tap_last ? '0 : tap + LF'(1);
      end
      if (state == ST_FLUSH) begin
        flush_cnt <= flush_last ? '0 : flush_cnt + LM'(1);
      end
      if (state == ST_STORE) begin
        pass_idx <= pass_last ? '0 : pass_idx + LY'(1);
        x_base   <= pass_last ? '0 : x_base + LX'(P);
      end
    end
  end

  // Output streaming: present an address, raise valid one cycle later, advance on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_valid_q <= 1'b0;
      point_idx <= '0;
      rd_addr   <= '0;
      lane_sel  <= '0;
    end else if (state == ST_DRAIN) begin
      if (!y_valid_q) begin
        y_valid_q <= 1'b1;
      end else if (y_hs) begin
        y_valid_q <= 1'b0;
        if (point_last) begin
          point_idx <= '0;
          rd_addr   <= '0;
          lane_sel  <= '0;
        end else begin
          point_idx <= point_idx + LK'(1);
          if (lane_last) begin
            lane_sel <= '0;
            rd_addr  <= rd_addr + LY'(1);
          end else begin
            lane_sel <= lane_sel + LP'(1);
          end
        end
      end
    end
  end

`ifdef CONV_SCHED_DONE_EN
  // Frame status: busy from the first accepted sample, done pulses after the final output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= y_hs & point_last;
      if (y_hs && point_last) busy <= 1'b0;
      else if (x_acc)         busy <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: self-checking bench for conv_sched. Instance a uses the default
// parameters and is checked by a scoreboard monitor; instance b uses a small
// multi-lane configuration and is checked from a table of drain vectors.
module tb_conv_sched;
  localparam int SX_A     = 96;
  localparam int SF_A     = 65;
  localparam int P_A      = 1;
  localparam int ML_A     = 3;
  localparam int POINTS_A = SX_A - SF_A + 1;
  localparam int PASSES_A = (POINTS_A + P_A - 1) / P_A;

  localparam int SX_B     = 10;
  localparam int SF_B     = 4;
  localparam int P_B      = 4;
  localparam int ML_B     = 3;

  typedef struct {
    int rd;
    int lane;
  } y_exp_t;

  typedef struct {
    int stall;
    int exp_rd;
    int exp_lane;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_err;

  int     xq[$];
  y_exp_t yq[$];
  int     hs_count;
  int     store_cnt;
  int     acc_cnt;
  int     last_hs;
  int     last_store;
  int     compute_start;
  bit     spacing_on;
  int     done_cnt;
  vec_t   vecs[7];

  conv_sched_if #(.SIZE_X(SX_A), .SIZE_F(SF_A), .P(P_A)) a_if ();
  conv_sched_if #(.SIZE_X(SX_B), .SIZE_F(SF_B), .P(P_B)) b_if ();

`ifdef CONV_SCHED_DONE_EN
  logic done_a;
  logic busy_a;
  logic done_b;
  logic busy_b;
`endif

  conv_sched #(.SIZE_X(SX_A), .SIZE_F(SF_A), .P(P_A), .MAC_LAT(ML_A)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.master)
`ifdef CONV_SCHED_DONE_EN
    ,
    .done  (done_a),
    .busy  (busy_a)
`endif
  );

  conv_sched #(.SIZE_X(SX_B), .SIZE_F(SF_B), .P(P_B), .MAC_LAT(ML_B)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
`ifdef CONV_SCHED_DONE_EN
    ,
    .done  (done_b),
    .busy  (busy_b)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency and spacing checks.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_output(input string name, input int actual, input int expected);
    n_chk++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  // Scoreboard monitor for instance a: sample writes, pass stores and output handshakes.
  always @(negedge clk) begin
    if (reset) begin
      if (xq.size() > 0) begin
        check_output("x_wr_en", int'(a_if.x_wr_en), 1);
        check_output("x_addr", int'(a_if.x_addr), xq.pop_front());
      end else begin
        check_output("x_wr_idle", int'(a_if.x_wr_en), 0);
      end
      if (a_if.acc_en) acc_cnt++;
      if (a_if.y_wr_en) begin
        check_output("y_wr_addr", int'(a_if.y_wr_addr), store_cnt);
        check_output("acc_en_per_pass", acc_cnt, SF_A);
        check_output("store_acc_clear", int'(a_if.acc_clear), 1);
        if (store_cnt == 0) check_output("store0_latency", cyc - compute_start, SF_A + ML_A);
        else                check_output("store_spacing", cyc - last_store, SF_A + ML_A + 1);
        last_store = cyc;
        store_cnt++;
        acc_cnt = 0;
      end
      if (a_if.y_valid && a_if.y_ready) begin
        if (yq.size() == 0) begin
          check_output("y_unexpected_hs", int'(a_if.y_valid), 0);
        end else begin
          y_exp_t e;
          e = yq.pop_front();
          check_output("y_rd_addr", int'(a_if.y_rd_addr), e.rd);
          check_output("y_lane_sel", int'(a_if.y_lane_sel), e.lane);
        end
        if (spacing_on) begin
          if (hs_count == 0) check_output("first_hs_latency", cyc - last_store, 2);
          else               check_output("hs_spacing", cyc - last_hs, 2);
        end
        last_hs = cyc;
        hs_count++;
      end
`ifdef CONV_SCHED_DONE_EN
      if (done_a) begin
        done_cnt++;
        check_output("done_after_hs", cyc - last_hs, 1);
        check_output("done_points", hs_count, POINTS_A);
        check_output("busy_at_done", int'(busy_a), 0);
      end
`endif
    end
  end

  // Loads one frame into instance a and checks the LOAD -> COMPUTE hand-over.
  task automatic apply_stimulus(input bit gaps, input bit hold_valid);
    hs_count  = 0;
    store_cnt = 0;
    acc_cnt   = 0;
    done_cnt  = 0;
    for (int k = 0; k < POINTS_A; k++) yq.push_back('{rd: k / P_A, lane: k % P_A});
`ifdef CONV_SCHED_DONE_EN
    check_output("busy_idle", int'(busy_a), 0);
`endif
    for (int i = 0; i < SX_A; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(2));
        repeat (g) begin
          a_if.x_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      a_if.x_valid = 1'b1;
      xq.push_back(i);
      @(posedge clk); #1;
    end
    if (!hold_valid) a_if.x_valid = 1'b0;
    @(negedge clk);
    compute_start = cyc;
    check_output("cmp_x_ready", int'(a_if.x_ready), 0);
    check_output("cmp_acc_clear", int'(a_if.acc_clear), 0);
    check_output("cmp_acc_en_first", int'(a_if.acc_en), 0);
    check_output("cmp_x_addr0", int'(a_if.x_addr), 0);
    check_output("cmp_f_addr0", int'(a_if.f_addr), 0);
`ifdef CONV_SCHED_DONE_EN
    check_output("busy_loaded", int'(busy_a), 1);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check_output("cmp_acc_en_second", int'(a_if.acc_en), 1);
    check_output("cmp_x_addr1", int'(a_if.x_addr), 1);
    check_output("cmp_f_addr1", int'(a_if.f_addr), 1);
    @(posedge clk); #1;
  endtask

  // Runs instance a until all output points are handshaken, optionally stalling point 5.
  task automatic wait_drain(input bit stall, input bit spacing);
    int n;
    bit stall_done;
    n = 0;
    stall_done = 1'b0;
    spacing_on = spacing;
    while (hs_count < POINTS_A && n < 4000) begin
      if (store_cnt > 0) a_if.x_valid = 1'b0;
      if (stall && !stall_done && hs_count == 5) begin
        a_if.y_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          if (j > 0) begin
            check_output("stall_y_valid", int'(a_if.y_valid), 1);
            check_output("stall_y_rd_addr", int'(a_if.y_rd_addr), 5);
          end
          @(posedge clk); #1;
        end
        a_if.y_ready = 1'b1;
        stall_done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    check_output("drain_points", hs_count, POINTS_A);
    check_output("store_count", store_cnt, PASSES_A);
    check_output("yq_empty", yq.size(), 0);
    @(negedge clk);
    check_output("end_x_ready", int'(a_if.x_ready), 1);
    check_output("end_x_addr", int'(a_if.x_addr), 0);
    check_output("end_acc_clear", int'(a_if.acc_clear), 1);
    check_output("end_y_valid", int'(a_if.y_valid), 0);
    @(posedge clk); #1;
`ifdef CONV_SCHED_DONE_EN
    @(negedge clk);
    check_output("done_per_frame", done_cnt, 1);
    check_output("busy_after_done", int'(busy_a), 0);
    @(posedge clk); #1;
`endif
  endtask

  // Small multi-lane instance: load, two passes, then table-driven drain with stalls.
  task automatic run_small();
    int n;
    b_if.y_ready = 1'b0;
    for (int i = 0; i < SX_B; i++) begin
      b_if.x_valid = 1'b1;
      @(negedge clk);
      check_output("b_x_wr_en", int'(b_if.x_wr_en), 1);
      check_output("b_x_addr_load", int'(b_if.x_addr), i);
      @(posedge clk); #1;
    end
    b_if.x_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int t = 0; t < SF_B; t++) begin
        @(negedge clk);
        check_output("b_x_addr_tap", int'(b_if.x_addr), p * P_B + t);
        check_output("b_f_addr", int'(b_if.f_addr), t);
        check_output("b_acc_en_tap", int'(b_if.acc_en), (t > 0) ? 1 : 0);
        check_output("b_x_ready_cmp", int'(b_if.x_ready), 0);
        @(posedge clk); #1;
      end
      for (int f = 0; f < ML_B; f++) begin
        @(negedge clk);
        check_output("b_acc_en_flush", int'(b_if.acc_en), (f == 0) ? 1 : 0);
        check_output("b_flush_wr", int'(b_if.y_wr_en), 0);
        check_output("b_flush_clear", int'(b_if.acc_clear), 0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check_output("b_y_wr_en", int'(b_if.y_wr_en), 1);
      check_output("b_y_wr_addr", int'(b_if.y_wr_addr), p);
      check_output("b_store_clear", int'(b_if.acc_clear), 1);
      @(posedge clk); #1;
    end
    for (int r = 0; r < 7; r++) begin
      b_if.y_ready = (vecs[r].stall == 0);
      n = 0;
      while (!b_if.y_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check_output("b_valid_wait", int'(b_if.y_valid), 1);
      for (int s = 0; s < vecs[r].stall; s++) begin
        @(posedge clk); #1;
        check_output("b_stall_valid", int'(b_if.y_valid), 1);
        check_output("b_stall_rd", int'(b_if.y_rd_addr), vecs[r].exp_rd);
      end
      b_if.y_ready = 1'b1;
      @(negedge clk);
      check_output("b_hs_valid", int'(b_if.y_valid), 1);
      check_output("b_y_rd_addr", int'(b_if.y_rd_addr), vecs[r].exp_rd);
      check_output("b_y_lane_sel", int'(b_if.y_lane_sel), vecs[r].exp_lane);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_output("b_end_x_ready", int'(b_if.x_ready), 1);
    check_output("b_end_y_valid", int'(b_if.y_valid), 0);
    check_output("b_end_x_addr", int'(b_if.x_addr), 0);
    @(posedge clk); #1;
  endtask

  // Main sequence: reset values, nominal frame, small config, gaps+stall, abort by reset.
  initial begin
    int n;
    vecs[0] = '{stall: 0, exp_rd: 0, exp_lane: 0};
    vecs[1] = '{stall: 3, exp_rd: 0, exp_lane: 1};
    vecs[2] = '{stall: 0, exp_rd: 0, exp_lane: 2};
    vecs[3] = '{stall: 1, exp_rd: 0, exp_lane: 3};
    vecs[4] = '{stall: 0, exp_rd: 1, exp_lane: 0};
    vecs[5] = '{stall: 2, exp_rd: 1, exp_lane: 1};
    vecs[6] = '{stall: 0, exp_rd: 1, exp_lane: 2};
    n_chk = 0;
    n_err = 0;
    hs_count = 0;
    store_cnt = 0;
    acc_cnt = 0;
    last_hs = 0;
    last_store = 0;
    compute_start = 0;
    spacing_on = 1'b0;
    done_cnt = 0;
    reset = 1'b1;
    a_if.x_valid = 1'b0;
    a_if.y_ready = 1'b1;
    b_if.x_valid = 1'b0;
    b_if.y_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("rst_x_ready", int'(a_if.x_ready), 1);
    check_output("rst_acc_clear", int'(a_if.acc_clear), 1);
    check_output("rst_acc_en", int'(a_if.acc_en), 0);
    check_output("rst_x_addr", int'(a_if.x_addr), 0);
    check_output("rst_y_wr_en", int'(a_if.y_wr_en), 0);
    check_output("rst_y_valid", int'(a_if.y_valid), 0);
    check_output("rst_b_x_ready", int'(b_if.x_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] nominal frame, x_valid and y_ready held high");
    apply_stimulus(1'b0, 1'b1);
    wait_drain(1'b0, 1'b1);

    $display("[TB] small configuration SIZE_X=10 SIZE_F=4 P=4");
    run_small();

    $display("[TB] random x_valid gaps and y_ready stall at point 5");
    apply_stimulus(1'b1, 1'b0);
    wait_drain(1'b1, 1'b0);

    $display("[TB] reset asserted during pass 10");
    apply_stimulus(1'b0, 1'b0);
    n = 0;
    while (store_cnt < 10 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("reached_pass10", store_cnt, 10);
    repeat (30) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    check_output("abort_x_ready", int'(a_if.x_ready), 1);
    check_output("abort_acc_clear", int'(a_if.acc_clear), 1);
    check_output("abort_acc_en", int'(a_if.acc_en), 0);
    check_output("abort_x_addr", int'(a_if.x_addr), 0);
    check_output("abort_f_addr", int'(a_if.f_addr), 0);
    check_output("abort_y_wr_addr", int'(a_if.y_wr_addr), 0);
    check_output("abort_y_valid", int'(a_if.y_valid), 0);
    xq.delete();
    yq.delete();
    @(posedge clk); #1;
    check_output("abort_hold_x_ready", int'(a_if.x_ready), 1);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    wait_drain(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
